// File: rtl/counter_monitor.sv
// Passive checker for an up-counter with load and overflow.
// It predicts count/overflow one cycle ahead and keeps saturating statistics.
module counter_monitor #(
    parameter int WIDTH       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] count,
    input  logic             overflow,
    input  logic             arm,
    input  logic             clear,
    output logic             checking,
    output logic             halted,
    output logic             mismatch,
    output logic [WIDTH-1:0] exp_count,
    output logic [7:0]       err_count,
    output logic [7:0]       ovf_count,
    output logic [15:0]      chk_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_exp_count;
    logic             r_exp_ovf;
    logic             r_mismatch;
    logic [7:0]       r_err_count;
    logic [7:0]       r_ovf_count;
    logic [15:0]      r_chk_count;

    logic [WIDTH-1:0] w_next_from_count;
    logic [WIDTH-1:0] w_next_from_exp;
    logic             w_wrap_from_count;
    logic             w_wrap_from_exp;
    logic             w_miss;

    // The model is applied both to the observed count (arm/resync) and to its own prediction.
    assign w_next_from_count = load ? load_value : (enable ? count + ONE : count);
    assign w_next_from_exp   = load ? load_value : (enable ? r_exp_count + ONE : r_exp_count);
    assign w_wrap_from_count = ~load & enable & (count == MAXV);
    assign w_wrap_from_exp   = ~load & enable & (r_exp_count == MAXV);
    assign w_miss            = (count != r_exp_count) || (overflow != r_exp_ovf);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (w_miss && STOP_ON_ERR) w_next_state = S_HALT;
                else if (!arm)             w_next_state = S_IDLE;
            end
            S_HALT: begin
                if (clear) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_exp_count <= '0;
            r_exp_ovf   <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= 8'd0;
            r_ovf_count <= 8'd0;
            r_chk_count <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_exp_count <= w_next_from_count;
                        r_exp_ovf   <= w_wrap_from_count;
                    end
                end
                S_CHECK: begin
                    r_mismatch <= w_miss;
                    if (r_chk_count != 16'hFFFF) r_chk_count <= r_chk_count + 16'd1;
                    if (overflow && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'd1;
                    if (w_miss) begin
                        r_exp_count <= w_next_from_count;
                        r_exp_ovf   <= w_wrap_from_count;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    end else begin
                        r_exp_count <= w_next_from_exp;
                        r_exp_ovf   <= w_wrap_from_exp;
                    end
                end
                default: ;
            endcase
            // Clear wins over any increment made on the same edge.
            if (clear) begin
                r_err_count <= 8'd0;
                r_ovf_count <= 8'd0;
                r_chk_count <= 16'd0;
            end
        end
    end

    assign checking  = (r_state == S_CHECK);
    assign halted    = (r_state == S_HALT);
    assign mismatch  = r_mismatch;
    assign exp_count = r_exp_count;
    assign err_count = r_err_count;
    assign ovf_count = r_ovf_count;
    assign chk_count = r_chk_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a free-running counter is observed by two monitors
// (STOP_ON_ERR=0 and =1) and both are compared every cycle against an integer model.
module tb_counter_monitor;

    localparam int W    = 8;
    localparam int MODV = 1 << W;
    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_HALT  = 2;

    logic         clk = 1'b0;
    logic         rst_n, enable, load, arm, clear, overflow;
    logic [W-1:0] load_value, count;

    logic         checking_o [2];
    logic         halted_o   [2];
    logic         mismatch_o [2];
    logic [W-1:0] exp_o      [2];
    logic [7:0]   err_o      [2];
    logic [7:0]   ovf_o      [2];
    logic [15:0]  chk_o      [2];
    logic [1:0]   dbg_o      [2];

    // Observed counter and fault injection
    int obs_cnt;
    bit obs_ovf;
    bit force_ovf;

    // Monitor model, one entry per instance
    int m_mode [2];
    int m_exp  [2];
    int m_eovf [2];
    int m_mm   [2];
    int m_err  [2];
    int m_ovf  [2];
    int m_chk  [2];

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_monitor #(.WIDTH(W), .STOP_ON_ERR(1'b0)) u_run (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_value(load_value),
        .count(count), .overflow(overflow), .arm(arm), .clear(clear),
        .checking(checking_o[0]), .halted(halted_o[0]), .mismatch(mismatch_o[0]),
        .exp_count(exp_o[0]), .err_count(err_o[0]), .ovf_count(ovf_o[0]),
        .chk_count(chk_o[0]), .dbg_state(dbg_o[0])
    );

    counter_monitor #(.WIDTH(W), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_value(load_value),
        .count(count), .overflow(overflow), .arm(arm), .clear(clear),
        .checking(checking_o[1]), .halted(halted_o[1]), .mismatch(mismatch_o[1]),
        .exp_count(exp_o[1]), .err_count(err_o[1]), .ovf_count(ovf_o[1]),
        .chk_count(chk_o[1]), .dbg_state(dbg_o[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int nxt(input int c);
        if (load) return int'(load_value);
        if (enable) return (c + 1) % MODV;
        return c;
    endfunction

    function automatic int wraps(input int c);
        return (!load && enable && c == MODV - 1) ? 1 : 0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step(input int p, input int c, input int o);
        int miss;
        int e_old;
        if (!rst_n) begin
            m_mode[p] = M_IDLE; m_exp[p] = 0; m_eovf[p] = 0; m_mm[p] = 0;
            m_err[p] = 0; m_ovf[p] = 0; m_chk[p] = 0;
            return;
        end
        if (m_mode[p] == M_IDLE) begin
            m_mm[p] = 0;
            if (arm) begin
                m_exp[p]  = nxt(c);
                m_eovf[p] = wraps(c);
                m_mode[p] = M_CHECK;
            end
        end else if (m_mode[p] == M_CHECK) begin
            miss     = (c != m_exp[p] || o != m_eovf[p]) ? 1 : 0;
            m_chk[p] = sat(m_chk[p] + 1, 65535);
            m_ovf[p] = sat(m_ovf[p] + o, 255);
            if (miss != 0) begin
                m_err[p]  = sat(m_err[p] + 1, 255);
                m_exp[p]  = nxt(c);
                m_eovf[p] = wraps(c);
            end else begin
                e_old     = m_exp[p];
                m_exp[p]  = nxt(e_old);
                m_eovf[p] = wraps(e_old);
            end
            m_mm[p] = miss;
            if (miss != 0 && p == 1) m_mode[p] = M_HALT;
            else if (!arm)           m_mode[p] = M_IDLE;
        end else begin
            m_mm[p] = 0;
            if (clear) m_mode[p] = M_IDLE;
        end
        if (clear) begin
            m_err[p] = 0; m_ovf[p] = 0; m_chk[p] = 0;
        end
    endtask

    // One clock: present observed counter, clock, update model and counter, compare.
    task automatic step();
        int c_pre;
        int o_pre;
        count    = obs_cnt[W-1:0];
        overflow = obs_ovf | force_ovf;
        c_pre    = int'(count);
        o_pre    = overflow ? 1 : 0;
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            model_step(p, c_pre, o_pre);
            exp_q.push_back(32'(m_mode[p] == M_CHECK));
            exp_q.push_back(32'(m_mode[p] == M_HALT));
            exp_q.push_back(32'(m_mm[p]));
            exp_q.push_back(32'(m_exp[p]));
            exp_q.push_back(32'(m_err[p]));
            exp_q.push_back(32'(m_ovf[p]));
            exp_q.push_back(32'(m_chk[p]));
        end
        obs_ovf = (!load && enable && obs_cnt == MODV - 1);
        if (load)        obs_cnt = int'(load_value);
        else if (enable) obs_cnt = (obs_cnt + 1) % MODV;
        #1;
        for (int p = 0; p < 2; p++) begin
            check_val($sformatf("i%0d_checking", p), 32'(checking_o[p]), exp_q.pop_front());
            check_val($sformatf("i%0d_halted", p),   32'(halted_o[p]),   exp_q.pop_front());
            check_val($sformatf("i%0d_mismatch", p), 32'(mismatch_o[p]), exp_q.pop_front());
            check_val($sformatf("i%0d_exp_count", p), 32'(exp_o[p]),     exp_q.pop_front());
            check_val($sformatf("i%0d_err_count", p), 32'(err_o[p]),     exp_q.pop_front());
            check_val($sformatf("i%0d_ovf_count", p), 32'(ovf_o[p]),     exp_q.pop_front());
            check_val($sformatf("i%0d_chk_count", p), 32'(chk_o[p]),     exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; enable = 1'b0; load = 1'b0;
        load_value = '0; obs_cnt = 0; obs_ovf = 1'b0; force_ovf = 1'b0;
        count = '0; overflow = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_mode[p] = M_IDLE; m_exp[p] = 0; m_eovf[p] = 0; m_mm[p] = 0;
            m_err[p] = 0; m_ovf[p] = 0; m_chk[p] = 0;
        end

        // Reset
        step(); step();
        check_val("rst_checking", 32'(checking_o[0]), 0);
        check_val("rst_halted", 32'(halted_o[1]), 0);

        // Tracking a correct counter for 50 compared cycles
        rst_n = 1'b1; arm = 1'b1; enable = 1'b1;
        step();
        repeat (50) step();
        check_val("track_chk0", 32'(chk_o[0]), 50);
        check_val("track_chk1", 32'(chk_o[1]), 50);
        check_val("track_err", 32'(err_o[0]), 0);
        check_val("track_exp", 32'(exp_o[0]), 51);

        // Load and enable together: load wins
        load = 1'b1; load_value = 8'h33;
        step();
        load = 1'b0;
        check_val("ld_en_exp", 32'(exp_o[0]), 32'h33);
        check_val("ld_en_mm", 32'(mismatch_o[0]), 0);

        // Wrap through FF with a single overflow pulse
        clear = 1'b1; step(); clear = 1'b0;
        enable = 1'b0; load = 1'b1; load_value = 8'hFE;
        step();
        load = 1'b0; enable = 1'b1;
        repeat (3) step();
        check_val("wrap_ovf", 32'(ovf_o[0]), 1);
        check_val("wrap_err", 32'(err_o[0]), 0);

        // Counter jumps to 10 while 0C is predicted
        enable = 1'b0; load = 1'b1; load_value = 8'h0B;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        obs_cnt = 32'h10;
        step();
        check_val("jump_mm", 32'(mismatch_o[0]), 1);
        check_val("jump_err", 32'(err_o[0]), 1);
        check_val("jump_resync", 32'(exp_o[0]), 32'h11);
        check_val("jump_halted", 32'(halted_o[1]), 1);
        repeat (3) step();
        check_val("jump_after_mm", 32'(mismatch_o[0]), 0);
        check_val("halt_chk_frozen", 32'(chk_o[1]), 7);

        // Clear releases the halted instance
        clear = 1'b1; step(); clear = 1'b0;
        check_val("clr_halted", 32'(halted_o[1]), 0);
        check_val("clr_checking", 32'(checking_o[1]), 0);
        check_val("clr_chk", 32'(chk_o[1]), 0);
        check_val("clr_err", 32'(err_o[1]), 0);

        // Three errors, then reset mid-check
        repeat (3) begin
            obs_cnt = (obs_cnt + 5) % MODV;
            step();
        end
        check_val("pre_rst_err", 32'(err_o[0]), 3);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_val("midrst_checking", 32'(checking_o[0]), 0);
        check_val("midrst_err", 32'(err_o[0]), 0);
        check_val("midrst_exp", 32'(exp_o[0]), 0);
        check_val("midrst_mm", 32'(mismatch_o[0]), 0);

        // Saturation of err_count and ovf_count
        clear = 1'b1; step(); clear = 1'b0;
        force_ovf = 1'b1;
        repeat (320) begin
            obs_cnt = int'($urandom_range(0, MODV - 1));
            step();
        end
        force_ovf = 1'b0;
        check_val("sat_err", 32'(err_o[0]), 255);
        check_val("sat_ovf", 32'(ovf_o[0]), 255);

        // Randomized traffic
        repeat (800) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            arm        = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 29) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 9) == 0);
            load_value = ($urandom_range(0, 2) == 0) ? 8'hFD : 8'($urandom);
            if ($urandom_range(0, 24) == 0) obs_cnt = obs_cnt ^ (1 << $urandom_range(0, W - 1));
            force_ovf  = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
